wb_trace_serializer: RTL and testbench

//  Debug-trace controller for the register-file write-back stage. Queues write-back events
//  and serializes each one as an ASCII line "<reg>=<8 hex>\n" on a byte stream for the
//  sim console or UART. It owns and sequences one shared regdef name decoder.

---
 rtl/trace_pkg.sv | 35 +++
 rtl/regdef.sv | 27 ++
 rtl/wb_trace_fifo.sv | 39 +++
 rtl/wb_trace_serializer.sv | 182 ++++++++++++++++++
 tb/tb_wb_trace_serializer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared types, character constants and helpers for the write-back trace serializer.
// Optional feature macro: TRACE_PC_EN (adds the PC to each entry and the PC/COLON/SPACE states).
package trace_pkg;

`ifdef TRACE_PC_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_PC, ST_COLON, ST_SPACE, ST_NAME, ST_EQ, ST_HEX, ST_NL
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_NAME, ST_EQ, ST_HEX, ST_NL
    } state_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;
`endif

    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;

    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

endpackage

// File: rtl/regdef.sv
// Register-number to assembler-name decoder; names are left-justified ASCII, NUL padded.
module regdef (
    input  logic [4:0]  addr,
    output logic [39:0] name
);

    function automatic logic [7:0] dig(input logic [4:0] a, input logic [4:0] base);
        return 8'h30 + {3'b000, 5'(a - base)};
    endfunction

    always_comb begin
        name = '0;
        if (addr == 5'd0)       name = {"$0", 24'h0};
        else if (addr == 5'd1)  name = {"at", 24'h0};
        else if (addr <= 5'd3)  name = {"v", dig(addr, 5'd2), 24'h0};
        else if (addr <= 5'd7)  name = {"a", dig(addr, 5'd4), 24'h0};
        else if (addr <= 5'd15) name = {"t", dig(addr, 5'd8), 24'h0};
        else if (addr <= 5'd23) name = {"s", dig(addr, 5'd16), 24'h0};
        else if (addr <= 5'd25) name = {"t", dig(addr, 5'd16), 24'h0};
        else if (addr <= 5'd27) name = {"k", dig(addr, 5'd26), 24'h0};
        else if (addr == 5'd28) name = {"gp", 24'h0};
        else if (addr == 5'd29) name = {"sp", 24'h0};
        else if (addr == 5'd30) name = {"fp", 24'h0};
        else                    name = {"ra", 24'h0};
    end

endmodule

// File: rtl/wb_trace_fifo.sv
// Event FIFO with extra-MSB pointers; head is the combinational read of the oldest entry.
module wb_trace_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  T     din,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr, rptr;
    T            mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_trace_serializer.sv
// Queues register write-back events and prints each as "<reg>=<8 hex>\n" on a byte stream.
// Optional feature macro: TRACE_PC_EN prefixes each line with "<pc 8 hex>: ".
module wb_trace_serializer
    import trace_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit SKIP_ZERO = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic [31:0]      wb_pc,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    input  logic             clr_stats
);

`ifdef TRACE_PC_EN
    localparam state_t ST_FIRST = ST_PC;
`else
    localparam state_t ST_FIRST = ST_NAME;
`endif

    state_t      state, state_n;
    entry_t      din, head, entry_q;
    logic        full, empty, push, pop, want_push, drop, load;
    logic [2:0]  hex_cnt, hex_cnt_n, name_idx, name_idx_n, name_sel;
    logic [39:0] reg_name;
    logic [7:0]  name_char, tx_data_n;
    logic        name_found, name_more, tx_valid_n;

    assign din.addr = wb_addr;
    assign din.data = wb_data;
`ifdef TRACE_PC_EN
    assign din.pc = wb_pc;
`else
    logic unused_pc;
    assign unused_pc = ^wb_pc;
`endif

    assign want_push = wb_en && !(SKIP_ZERO && (wb_addr == 5'd0));
    assign push      = want_push && (!full || pop);
    assign drop      = want_push && !push;
    assign load      = !tx_valid || tx_ready;
    assign busy      = !empty || (state != ST_IDLE) || tx_valid;

    wb_trace_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk(clk), .resetn(resetn), .push(push), .pop(pop),
        .din(din), .full(full), .empty(empty), .head(head)
    );

    regdef u_regdef (.addr(entry_q.addr), .name(reg_name));

    // Pick the next non-NUL name byte at or after name_idx, and whether another follows it.
    always_comb begin
        name_found = 1'b0;
        name_more  = 1'b0;
        name_sel   = '0;
        name_char  = '0;
        for (int i = 0; i < 5; i++) begin
            if (!name_found && (3'(i) >= name_idx) && (reg_name[8*(4-i) +: 8] != 8'h00)) begin
                name_found = 1'b1;
                name_sel   = 3'(i);
                name_char  = reg_name[8*(4-i) +: 8];
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (name_found && (3'(i) > name_sel) && (reg_name[8*(4-i) +: 8] != 8'h00))
                name_more = 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        hex_cnt_n  = hex_cnt;
        name_idx_n = name_idx;
        tx_valid_n = tx_valid;
        tx_data_n  = tx_data;
        if (state == ST_IDLE) begin
            if (load) tx_valid_n = 1'b0;
            if (!empty) begin
                pop        = 1'b1;
                state_n    = ST_FIRST;
                hex_cnt_n  = 3'd7;
                name_idx_n = '0;
            end
        end else if (load) begin
            tx_valid_n = 1'b1;
            case (state)
`ifdef TRACE_PC_EN
                ST_PC: begin
                    tx_data_n = hex2ascii(entry_q.pc[{hex_cnt, 2'b00} +: 4]);
                    hex_cnt_n = hex_cnt - 3'd1;
                    if (hex_cnt == 3'd0) state_n = ST_COLON;
                end
                ST_COLON: begin
                    tx_data_n = CH_COLON;
                    state_n   = ST_SPACE;
                end
                ST_SPACE: begin
                    tx_data_n = CH_SPACE;
                    state_n   = ST_NAME;
                end
`endif
                ST_NAME: begin
                    if (name_found) begin
                        tx_data_n  = name_char;
                        name_idx_n = name_sel + 3'd1;
                        if (!name_more) state_n = ST_EQ;
                    end else begin
                        tx_data_n = CH_EQ;
                        state_n   = ST_HEX;
                        hex_cnt_n = 3'd7;
                    end
                end
                ST_EQ: begin
                    tx_data_n = CH_EQ;
                    state_n   = ST_HEX;
                    hex_cnt_n = 3'd7;
                end
                ST_HEX: begin
                    tx_data_n = hex2ascii(entry_q.data[{hex_cnt, 2'b00} +: 4]);
                    hex_cnt_n = hex_cnt - 3'd1;
                    if (hex_cnt == 3'd0) state_n = ST_NL;
                end
                ST_NL: begin
                    // Chain straight into the next queued event so lines run back to back.
                    tx_data_n = CH_NL;
                    if (!empty) begin
                        pop        = 1'b1;
                        state_n    = ST_FIRST;
                        hex_cnt_n  = 3'd7;
                        name_idx_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            hex_cnt  <= '0;
            name_idx <= '0;
            entry_q  <= '0;
        end else begin
            state    <= state_n;
            tx_valid <= tx_valid_n;
            tx_data  <= tx_data_n;
            hex_cnt  <= hex_cnt_n;
            name_idx <= name_idx_n;
            if (pop) entry_q <= head;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_stats) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Directed self-checking bench for wb_trace_serializer; a second instance covers SKIP_ZERO=0 and a 2-bit drop counter.
module tb_wb_trace_serializer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] wb_pc = '0;
    logic        tx_ready = 1'b0;
    logic        clr_stats = 1'b0;

    logic        tx_valid, busy, overflow;
    logic [7:0]  tx_data;
    logic [15:0] drop_cnt;

    logic        tx_valid0, busy0, overflow0;
    logic [7:0]  tx_data0;
    logic [1:0]  drop_cnt0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    string pfx;

    logic [7:0] got [$];
    int         got_cyc [$];
    logic [7:0] got0 [$];

    wb_trace_serializer #(.DEPTH(4), .SKIP_ZERO(1'b1), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_pc(wb_pc), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt), .clr_stats(clr_stats)
    );

    wb_trace_serializer #(.DEPTH(4), .SKIP_ZERO(1'b0), .CNT_W(2)) dut0 (
        .clk(clk), .resetn(resetn), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_pc(wb_pc), .tx_valid(tx_valid0), .tx_ready(tx_ready), .tx_data(tx_data0),
        .busy(busy0), .overflow(overflow0), .drop_cnt(drop_cnt0), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            got.push_back(tx_data);
            got_cyc.push_back(cyc);
        end
        if (tx_valid0 && tx_ready) got0.push_back(tx_data0);
    end

    function automatic string q2s(input logic [7:0] q [$]);
        string s = "";
        foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
        return s;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        wb_en = 1'b0;
        clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        got.delete();
        got_cyc.delete();
        got0.delete();
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p, input logic clr);
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        wb_pc = p;
        clr_stats = clr;
        @(posedge clk);
        #1 wb_en = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic wait_chars(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (got.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_valid got %b want 0", tx_valid); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
        vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        do_reset();
    endtask

    task automatic test_basic_line();
        bit ok;
        string exp_s = {pfx, "t0=deadbeef\n"};
        logic [7:0] first_ch = (pfx.len() > 0) ? pfx[0] : 8'h74;
        do_reset();
        tx_ready = 1'b1;
        push(5'd8, 32'hDEADBEEF, 32'h0, 1'b0);
        @(negedge clk);
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_early1 tx_valid got %b want 0", tx_valid); end
        @(negedge clk);
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_early2 tx_valid got %b want 0", tx_valid); end
        @(negedge clk);
        vectors++; if (tx_valid !== 1'b1 || tx_data !== first_ch) begin miscompares++; $display("[TB] FAIL first_char got v=%b %h want v=1 %h", tx_valid, tx_data, first_ch); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_in_line got %b want 1", busy); end
        wait_chars(exp_s.len(), 60, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL basic_timeout got %0d chars want %0d", got.size(), exp_s.len()); end
        vectors++; if (q2s(got) != exp_s) begin miscompares++; $display("[TB] FAIL basic_line got \"%s\" want \"%s\"", q2s(got), exp_s); end
        if (ok) begin
            vectors++; if (got_cyc[exp_s.len()-1] - got_cyc[0] !== exp_s.len() - 1) begin miscompares++; $display("[TB] FAIL basic_rate got %0d cycles want %0d", got_cyc[exp_s.len()-1] - got_cyc[0], exp_s.len() - 1); end
        end
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_after_nl got %b want 0", busy); end
    endtask

    task automatic test_skip_zero();
        string exp0 = {pfx, "$0=00000000\n"};
        do_reset();
        tx_ready = 1'b1;
        push(5'd0, 32'h0, 32'h0, 1'b0);
        repeat (30) @(negedge clk);
        vectors++; if (got.size() !== 0) begin miscompares++; $display("[TB] FAIL skip_zero_chars got %0d want 0", got.size()); end
        vectors++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL skip_zero_stats got ovf=%b cnt=%0d want 0/0", overflow, drop_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL skip_zero_busy got %b want 0", busy); end
        vectors++; if (q2s(got0) != exp0) begin miscompares++; $display("[TB] FAIL no_skip_line got \"%s\" want \"%s\"", q2s(got0), exp0); end
    endtask

    task automatic test_stall();
        string exp_s = {pfx, "v0=0123abcd\n"};
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        do_reset();
        tx_ready = 1'b0;
        push(5'd2, 32'h0123ABCD, 32'h0, 1'b0);
        for (int c = 0; c < 100 && got.size() < exp_s.len(); c++) begin
            @(negedge clk);
            if (prev_stall) begin
                vectors++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin miscompares++; $display("[TB] FAIL stall_hold got v=%b %h want v=1 %h", tx_valid, tx_data, prev_data); end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
            @(posedge clk);
            #1 tx_ready = ~tx_ready;
        end
        repeat (4) @(negedge clk);
        vectors++; if (q2s(got) != exp_s) begin miscompares++; $display("[TB] FAIL stall_line got \"%s\" want \"%s\"", q2s(got), exp_s); end
    endtask

    task automatic test_overflow();
        bit ok;
        string exp_s = {pfx, "t1=00000000\n", pfx, "s0=00000001\n", pfx, "s1=00000002\n",
                        pfx, "s2=00000003\n", pfx, "s3=00000004\n"};
        do_reset();
        tx_ready = 1'b0;
        push(5'd9, 32'h0, 32'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) push(5'(16 + k), 32'(k + 1), 32'h0, 1'b0);
        @(negedge clk);
        vectors++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL overflow_stats got ovf=%b cnt=%0d want 1/2", overflow, drop_cnt); end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_chars(exp_s.len(), 200, ok);
        repeat (10) @(negedge clk);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL overflow_timeout got %0d chars want %0d", got.size(), exp_s.len()); end
        vectors++; if (q2s(got) != exp_s) begin miscompares++; $display("[TB] FAIL overflow_lines got \"%s\" want \"%s\"", q2s(got), exp_s); end
        if (ok) begin
            vectors++; if (got_cyc[exp_s.len()-1] - got_cyc[0] !== exp_s.len() - 1) begin miscompares++; $display("[TB] FAIL back_to_back got %0d cycles want %0d", got_cyc[exp_s.len()-1] - got_cyc[0], exp_s.len() - 1); end
        end
        @(posedge clk);
        #1 clr_stats = 1'b1;
        @(posedge clk);
        #1 clr_stats = 1'b0;
        @(negedge clk);
        vectors++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL clr_stats got ovf=%b cnt=%0d want 0/0", overflow, drop_cnt); end
    endtask

    task automatic test_clr_wins();
        do_reset();
        tx_ready = 1'b0;
        push(5'd9, 32'h0, 32'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) push(5'(16 + k), 32'(k), 32'h0, 1'b0);
        @(negedge clk);
        vectors++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL first_drop got ovf=%b cnt=%0d want 1/1", overflow, drop_cnt); end
        @(posedge clk);
        #1 push(5'd3, 32'h5, 32'h0, 1'b1);
        @(negedge clk);
        vectors++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL clr_beats_drop got ovf=%b cnt=%0d want 0/0", overflow, drop_cnt); end
        @(posedge clk);
        #1 push(5'd4, 32'h6, 32'h0, 1'b0);
        @(negedge clk);
        vectors++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL drop_after_clr got ovf=%b cnt=%0d want 1/1", overflow, drop_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        tx_ready = 1'b0;
        push(5'd9, 32'h0, 32'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) push(5'(1 + k), 32'(k), 32'h0, 1'b0);
        @(negedge clk);
        vectors++; if (drop_cnt !== 16'd5) begin miscompares++; $display("[TB] FAIL drop_cnt_wide got %0d want 5", drop_cnt); end
        vectors++; if (drop_cnt0 !== 2'b11 || overflow0 !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_cnt_saturate got ovf=%b cnt=%0d want 1/3", overflow0, drop_cnt0); end
    endtask

    task automatic test_reset_mid_line();
        bit ok;
        int snap;
        string exp_s = {pfx, "t0=cafef00d\n"};
        do_reset();
        tx_ready = 1'b1;
        push(5'd8, 32'hDEADBEEF, 32'h0, 1'b0);
        wait_chars(pfx.len() + 5, 40, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL mid_reset_timeout got %0d chars want %0d", got.size(), pfx.len() + 5); end
        resetn = 1'b0;
        #1;
        vectors++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset got v=%b d=%h busy=%b want 0/00/0", tx_valid, tx_data, busy); end
        snap = got.size();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (20) @(negedge clk);
        vectors++; if (got.size() !== snap || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL no_tail_chars got %0d chars busy=%b want %0d/0", got.size(), busy, snap); end
        got.delete();
        got_cyc.delete();
        @(posedge clk);
        #1 push(5'd8, 32'hCAFEF00D, 32'h0, 1'b0);
        wait_chars(exp_s.len(), 60, ok);
        repeat (3) @(negedge clk);
        vectors++; if (q2s(got) != exp_s) begin miscompares++; $display("[TB] FAIL post_reset_line got \"%s\" want \"%s\"", q2s(got), exp_s); end
    endtask

`ifdef TRACE_PC_EN
    task automatic test_pc_prefix();
        bit ok;
        string exp_s = "00400010: ra=00000001\n";
        do_reset();
        tx_ready = 1'b1;
        push(5'd31, 32'h1, 32'h00400010, 1'b0);
        wait_chars(exp_s.len(), 80, ok);
        repeat (3) @(negedge clk);
        vectors++; if (q2s(got) != exp_s) begin miscompares++; $display("[TB] FAIL pc_line got \"%s\" want \"%s\"", q2s(got), exp_s); end
    endtask
`endif

    initial begin
`ifdef TRACE_PC_EN
        pfx = "00000000: ";
`else
        pfx = "";
`endif
        test_reset();
        test_basic_line();
        test_skip_zero();
        test_stall();
        test_overflow();
        test_clr_wins();
        test_saturate();
        test_reset_mid_line();
`ifdef TRACE_PC_EN
        test_pc_prefix();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
